// File: rtl/data_bus_bridge_if.sv
// CPU data-port bundle between the pipeline (master) and the data bus bridge (slave).
interface data_bus_bridge_if;
   logic [31:0] cpu_addr;
   logic        cpu_re;
   logic        cpu_we;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_mask;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;

   modport master (
      output cpu_addr, cpu_re, cpu_we, cpu_wdata, cpu_mask,
      input  cpu_rdata, cpu_stall
   );

   modport slave (
      input  cpu_addr, cpu_re, cpu_we, cpu_wdata, cpu_mask,
      output cpu_rdata, cpu_stall
   );
endinterface

// File: rtl/data_bus_bridge.sv
// Registered CPU data-port decoder/sequencer for the data SRAM, UART and VGA framebuffer.
// Define DBUS_ERR_CAPTURE_EN to latch the first unmapped access address on err_valid/err_addr.
module data_bus_bridge #(
   parameter int unsigned SRAM_LAT = 2,
   parameter int unsigned UART_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   data_bus_bridge_if.slave cpu,
   output logic             sram_re,
   output logic             sram_we,
   output logic [31:0]      sram_addr,
   output logic [31:0]      sram_wdata,
   output logic [3:0]       sram_mask,
   input  logic [31:0]      sram_rdata,
   output logic             uart_re,
   output logic             uart_we,
   output logic [31:0]      uart_wdata,
   input  logic [31:0]      uart_rdata,
   input  logic [1:0]       uart_mode,
   output logic             vga_we,
   output logic [31:0]      vga_addr,
   output logic [31:0]      vga_wdata,
   output logic             err_valid,
   output logic [31:0]      err_addr,
   input  logic             err_clr
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
   typedef enum logic [2:0] {TgtNone, TgtSram, TgtUart, TgtStat, TgtVga} tgt_e;

   localparam logic [7:0] SramLat = 8'(SRAM_LAT);
   localparam logic [7:0] UartLat = 8'(UART_LAT);

   state_e      state_q, state_d;
   tgt_e        tgt_q, tgt_d, tgt_dec;
   logic [7:0]  lat_q, lat_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, rd_sel;
   logic [3:0]  mask_q, mask_d;
   logic        we_q, we_d;
   logic        req;

   assign req = cpu.cpu_re | cpu.cpu_we;

   always_comb begin
      tgt_dec = TgtNone;
      if (cpu.cpu_addr >= 32'h8040_0000 && cpu.cpu_addr <= 32'h807F_FFFF) begin
         tgt_dec = TgtSram;
      end else if (cpu.cpu_addr == 32'hBFD0_03F8) begin
         tgt_dec = TgtUart;
      end else if (cpu.cpu_addr == 32'hBFD0_03FC) begin
         tgt_dec = TgtStat;
      end else if (cpu.cpu_addr >= 32'hBA00_0000 && cpu.cpu_addr <= 32'hBA07_52FF) begin
         tgt_dec = TgtVga;
      end
   end

   always_comb begin
      rd_sel = '0;
      unique case (tgt_q)
         TgtSram: rd_sel = sram_rdata;
         TgtUart: rd_sel = uart_rdata;
         TgtStat: rd_sel = {30'b0, uart_mode};
         default: rd_sel = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      lat_d   = lat_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               addr_d  = cpu.cpu_addr;
               wdata_d = cpu.cpu_wdata;
               mask_d  = cpu.cpu_mask;
               we_d    = cpu.cpu_we;
               tgt_d   = tgt_dec;
               unique case (tgt_dec)
                  TgtSram: lat_d = SramLat;
                  TgtUart: lat_d = UartLat;
                  default: lat_d = 8'd1;
               endcase
               state_d = StAccess;
            end
         end
         StAccess: begin
            // Read data is sampled on the final strobe cycle of the access.
            if (lat_q <= 8'd1) begin
               rdata_d = we_q ? 32'h0 : rd_sel;
               lat_d   = '0;
               state_d = StDone;
            end else begin
               lat_d = lat_q - 8'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         tgt_q   <= TgtNone;
         lat_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         lat_q   <= lat_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      sram_re = 1'b0;
      sram_we = 1'b0;
      uart_re = 1'b0;
      uart_we = 1'b0;
      vga_we  = 1'b0;
      if (state_q == StAccess) begin
         unique case (tgt_q)
            TgtSram: begin
               sram_re = !we_q;
               sram_we = we_q;
            end
            TgtUart: begin
               uart_re = !we_q;
               uart_we = we_q;
            end
            TgtVga:  vga_we = we_q;
            default: ;
         endcase
      end
   end

   assign sram_addr     = {10'b0, addr_q[21:0]};
   assign sram_wdata    = wdata_q;
   assign sram_mask     = mask_q;
   assign uart_wdata    = wdata_q;
   assign vga_addr      = addr_q & 32'h000F_FFFF;
   assign vga_wdata     = wdata_q;
   assign cpu.cpu_rdata = rdata_q;
   assign cpu.cpu_stall = ((state_q == StIdle) && req) || (state_q == StAccess);

`ifdef DBUS_ERR_CAPTURE_EN
   logic        err_valid_q, err_valid_d, err_cap;
   logic [31:0] err_addr_q, err_addr_d;

   assign err_cap = (state_q == StIdle) && req && (tgt_dec == TgtNone);

   always_comb begin
      err_valid_d = err_valid_q;
      err_addr_d  = err_addr_q;
      if (err_clr) begin
         err_valid_d = 1'b0;
         err_addr_d  = '0;
      end
      // A clear coinciding with a fresh unmapped access lets the new address latch.
      if (err_cap && (!err_valid_q || err_clr)) begin
         err_valid_d = 1'b1;
         err_addr_d  = cpu.cpu_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
      end else begin
         err_valid_q <= err_valid_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign err_valid = err_valid_q;
   assign err_addr  = err_addr_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_valid      = 1'b0;
   assign err_addr       = '0;
`endif

endmodule
